// File: rtl/ball_physics.sv
// Ball physics for the falling-platform game: position, vertical velocity,
// world scroll, survival score and fail detection, advanced once per frame tick.
module ball_physics #(
  parameter int SCREEN_W   = 320,
  parameter int SCREEN_H   = 240,
  parameter int BALL_SIZE  = 8,
  parameter int XW         = 9,
  parameter int YW         = 9,
  parameter int VW         = 6,
  parameter int TICK_DIV   = 1666666,
  parameter int X_STEP     = 2,
  parameter int SCROLL     = 1,
  parameter int GRAVITY    = 1,
  parameter int VMAX       = 6,
  parameter int JUMP_V     = 8,
  parameter int TOP_MARGIN = 4,
  parameter int Y_INIT     = 120
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 move_left,
  input  logic                 move_right,
  input  logic                 jump,
  input  logic                 pause,
  input  logic                 on_platform,
  output logic [XW-1:0]        x_ball,
  output logic [YW-1:0]        y_ball,
  output logic [YW-1:0]        y_pixel_offset,
  output logic signed [VW-1:0] vy,
  output logic [15:0]          score,
  output logic                 fail,
  output logic                 frame_tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int YE = YW + 2;

  localparam logic [CW-1:0]        TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [XW-1:0]        X_INIT    = XW'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [XW-1:0]        X_MAX     = XW'(SCREEN_W - BALL_SIZE);
  localparam logic [XW-1:0]        X_STEP_X  = XW'(X_STEP);
  localparam logic [YW-1:0]        Y_START   = YW'(Y_INIT);
  localparam logic [YW-1:0]        Y_TOP     = YW'(TOP_MARGIN);
  localparam logic [YW-1:0]        Y_BOT     = YW'(SCREEN_H - BALL_SIZE);
  localparam logic signed [YE-1:0] TOP_S     = YE'(TOP_MARGIN);
  localparam logic signed [YE-1:0] BOT_S     = YE'(SCREEN_H - BALL_SIZE);
  localparam logic signed [YE-1:0] JUMP_S    = YE'(JUMP_V);
  localparam logic signed [YE-1:0] SCROLL_S  = YE'(SCROLL);
  localparam logic signed [VW:0]   GRAV_S    = (VW+1)'(GRAVITY);
  localparam logic signed [VW:0]   VMAX_S    = (VW+1)'(VMAX);
  localparam logic signed [VW-1:0] VY_JUMP   = VW'(-JUMP_V);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_FAILED} state_t;

  state_t        state;
  logic [CW-1:0] tick_cnt;
  logic          jump_d, pause_d;
  logic          jump_req, pause_req;
  logic          jump_pend, pause_pend;

  logic [XW-1:0]        x_next;
  logic [XW:0]          x_sum;
  logic [YW:0]          off_sum;
  logic [YW-1:0]        off_next;
  logic signed [YE-1:0] y_ext, y_new;
  logic signed [VW:0]   vy_inc, vy_cl;
  logic signed [VW-1:0] vy_next;
  logic [YW-1:0]        y_next;
  logic                 hit;
  logic [15:0]          score_next;

  assign frame_tick = (tick_cnt == TICK_LAST);
  // A rising edge in the tick cycle itself still counts for this frame.
  assign jump_pend  = jump_req  | (jump  & ~jump_d);
  assign pause_pend = pause_req | (pause & ~pause_d);

  always_comb begin
    x_next = x_ball;
    x_sum  = {1'b0, x_ball} + {1'b0, X_STEP_X};
    if (move_left && !move_right)
      x_next = (x_ball < X_STEP_X) ? '0 : x_ball - X_STEP_X;
    else if (move_right && !move_left)
      x_next = (x_sum > {1'b0, X_MAX}) ? X_MAX : x_sum[XW-1:0];

    off_sum  = {1'b0, y_pixel_offset} + (YW+1)'(SCROLL);
    off_next = (off_sum >= (YW+1)'(SCREEN_H)) ? YW'(off_sum - (YW+1)'(SCREEN_H))
                                              : off_sum[YW-1:0];

    // Vertical arithmetic in two extra signed bits so under/overflow stays visible.
    y_ext   = signed'({2'b00, y_ball});
    vy_inc  = signed'({vy[VW-1], vy}) + GRAV_S;
    vy_cl   = (vy_inc > VMAX_S) ? VMAX_S : vy_inc;
    vy_next = vy;
    y_new   = y_ext;
    if (on_platform && !vy[VW-1]) begin
      if (jump_pend) begin
        vy_next = VY_JUMP;
        y_new   = y_ext - JUMP_S;
      end else begin
        vy_next = '0;
        y_new   = y_ext - SCROLL_S;
      end
    end else begin
      vy_next = vy_cl[VW-1:0];
      y_new   = y_ext + signed'({{(YE-VW-1){vy_cl[VW]}}, vy_cl});
    end

    hit    = 1'b0;
    y_next = y_new[YW-1:0];
    if (y_new <= TOP_S) begin
      hit    = 1'b1;
      y_next = Y_TOP;
    end else if (y_new >= BOT_S) begin
      hit    = 1'b1;
      y_next = Y_BOT;
    end

    score_next = (score == 16'hFFFF) ? score : score + 16'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= S_IDLE;
      tick_cnt       <= '0;
      jump_d         <= 1'b0;
      pause_d        <= 1'b0;
      jump_req       <= 1'b0;
      pause_req      <= 1'b0;
      x_ball         <= X_INIT;
      y_ball         <= Y_START;
      y_pixel_offset <= '0;
      vy             <= '0;
      score          <= '0;
      fail           <= 1'b0;
    end else begin
      jump_d   <= jump;
      pause_d  <= pause;
      tick_cnt <= frame_tick ? '0 : tick_cnt + CW'(1);

      if (frame_tick) begin
        jump_req  <= 1'b0;
        pause_req <= 1'b0;
        case (state)
          S_IDLE: if (jump_pend) state <= S_RUN;
          S_RUN: begin
            if (pause_pend) begin
              state <= S_PAUSED;
            end else begin
              x_ball         <= x_next;
              y_pixel_offset <= off_next;
              vy             <= vy_next;
              y_ball         <= y_next;
              if (hit) begin
                state <= S_FAILED;
                fail  <= 1'b1;
              end else begin
                score <= score_next;
              end
            end
          end
          S_PAUSED: if (pause_pend) state <= S_RUN;
          S_FAILED: begin
            if (jump_pend) begin
              state          <= S_IDLE;
              x_ball         <= X_INIT;
              y_ball         <= Y_START;
              y_pixel_offset <= '0;
              vy             <= '0;
              score          <= '0;
              fail           <= 1'b0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end else begin
        if (jump & ~jump_d)   jump_req  <= 1'b1;
        if (pause & ~pause_d) pause_req <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ball_physics.sv
// Directed bench for ball_physics with a 4-clk frame; expectations are hand-derived.
module tb_ball_physics;

  logic              clk = 1'b0;
  logic              rstn;
  logic              move_left, move_right, jump, pause, on_platform;
  logic [8:0]        x_ball, y_ball, y_pixel_offset;
  logic signed [5:0] vy;
  logic [15:0]       score;
  logic              fail, frame_tick;

  int checks = 0;
  int errors = 0;
  int es = 0, eo = 0, ey = 0, evy = 0;
  bit hov = 1'b0;
  int fall_y[6] = '{121, 123, 126, 130, 135, 141};

  ball_physics #(.TICK_DIV(4)) dut (
    .clk(clk), .rstn(rstn), .move_left(move_left), .move_right(move_right),
    .jump(jump), .pause(pause), .on_platform(on_platform),
    .x_ball(x_ball), .y_ball(y_ball), .y_pixel_offset(y_pixel_offset),
    .vy(vy), .score(score), .fail(fail), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk(input string tag, input int x, input int y, input int v,
                     input int s, input int o, input int f);
    $display("%s: x=%0d y=%0d vy=%0d score=%0d off=%0d fail=%0d", tag,
             x_ball, y_ball, $signed(vy), score, y_pixel_offset, fail);
    check({tag, ".x"}, int'(x_ball), x);
    check({tag, ".y"}, int'(y_ball), y);
    check({tag, ".vy"}, int'($signed(vy)), v);
    check({tag, ".score"}, int'(score), s);
    check({tag, ".off"}, int'(y_pixel_offset), o);
    check({tag, ".fail"}, int'(fail), f);
  endtask

  // Advance past the next frame tick; inputs set beforehand apply to it.
  task automatic next_frame();
    int n = 0;
    @(negedge clk);
    while (!frame_tick && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!frame_tick) check("frame_tick_timeout", int'(frame_tick), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_jump();
    jump = 1'b1;
    @(posedge clk);
    #1;
    jump = 1'b0;
  endtask

  task automatic pulse_pause();
    pause = 1'b1;
    @(posedge clk);
    #1;
    pause = 1'b0;
  endtask

  // Alternates falling one pixel and landing, so the ball stays near one height.
  task automatic hover();
    on_platform = hov;
    next_frame();
    if (!hov) begin
      evy = 1;
      ey  = ey + 1;
    end else begin
      evy = 0;
      ey  = ey - 1;
    end
    hov = ~hov;
    es++;
    eo = (eo + 1) % 240;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, p;
    rstn = 1'b0;
    move_left = 0; move_right = 0; jump = 0; pause = 0; on_platform = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.frame_tick", int'(frame_tick), 0);
    chk("reset", 156, 120, 0, 0, 0, 0);

    @(negedge clk) rstn = 1'b1;
    n = 0;
    while (!frame_tick && n < 20) begin @(negedge clk); n++; end
    p = 1;
    @(negedge clk);
    while (!frame_tick && p < 20) begin @(negedge clk); p++; end
    check("tick_period", p, 4);
    @(posedge clk);
    #1;

    next_frame();
    chk("idle_hold", 156, 120, 0, 0, 0, 0);
    pulse_jump();
    next_frame();
    chk("start", 156, 120, 0, 0, 0, 0);

    on_platform = 0;
    for (int i = 0; i < 6; i++) begin
      next_frame(); es++; eo++;
      chk("fall", 156, fall_y[i], i + 1, es, eo, 0);
    end
    next_frame(); es++; eo++;
    chk("fall_vmax", 156, 147, 6, es, eo, 0);

    on_platform = 1;
    next_frame(); es++; eo++;
    chk("land", 156, 146, 0, es, eo, 0);
    next_frame(); es++; eo++;
    chk("carry", 156, 145, 0, es, eo, 0);
    pulse_jump();
    next_frame(); es++; eo++;
    chk("jump", 156, 137, -8, es, eo, 0);
    on_platform = 0;
    pulse_jump();
    next_frame(); es++; eo++;
    chk("air_jump_ignored", 156, 130, -7, es, eo, 0);
    on_platform = 1;
    next_frame(); es++; eo++;
    chk("rising_on_plat", 156, 124, -6, es, eo, 0);
    on_platform = 0;
    repeat (6) begin next_frame(); es++; eo++; end
    chk("apex", 156, 109, 0, es, eo, 0);

    ey = 109; evy = 0; hov = 1'b0;
    move_left = 1;
    repeat (77) hover();
    chk("left_near", 2, ey, evy, es, eo, 0);
    hover();
    chk("left_edge", 0, ey, evy, es, eo, 0);
    hover();
    chk("left_clamp", 0, ey, evy, es, eo, 0);
    move_left = 0;
    move_right = 1;
    repeat (155) hover();
    chk("right_near", 310, ey, evy, es, eo, 0);
    hover();
    chk("right_edge", 312, ey, evy, es, eo, 0);
    hover();
    chk("right_clamp", 312, ey, evy, es, eo, 0);
    move_left = 1;
    hover();
    chk("both_keys", 312, ey, evy, es, eo, 0);
    move_left = 0; move_right = 0;

    repeat (224) hover();
    check("off_239", int'(y_pixel_offset), 239);
    hover();
    check("off_wrap", int'(y_pixel_offset), 0);
    chk("after_wrap", 312, 109, 0, 480, 0, 0);

    pulse_pause();
    on_platform = 0;
    next_frame();
    chk("pause_enter", 312, 109, 0, 480, 0, 0);
    repeat (10) next_frame();
    chk("pause_hold", 312, 109, 0, 480, 0, 0);
    pulse_jump();
    next_frame();
    chk("pause_jump_ignored", 312, 109, 0, 480, 0, 0);
    pulse_pause();
    next_frame();
    chk("resume", 312, 109, 0, 480, 0, 0);
    hov = 1'b0;
    hover();
    chk("resume_run", 312, 110, 1, 481, 1, 0);
    hover();

    on_platform = 1;
    pulse_pause();
    pulse_jump();
    next_frame();
    chk("pause_and_jump", 312, 109, 0, 482, 2, 0);
    pulse_pause();
    next_frame();
    next_frame();
    chk("no_stale_jump", 312, 108, 0, 483, 3, 0);

    es = 483; eo = 3;
    on_platform = 0;
    repeat (23) begin next_frame(); es++; eo++; end
    chk("fall_to_231", 312, 231, 6, es, eo, 0);
    next_frame(); eo++;
    chk("fail_bottom", 312, 232, 6, 506, 27, 1);
    repeat (3) next_frame();
    chk("fail_hold", 312, 232, 6, 506, 27, 1);
    pulse_jump();
    next_frame();
    chk("restart", 156, 120, 0, 0, 0, 0);
    pulse_jump();
    next_frame();
    chk("restart_run", 156, 120, 0, 0, 0, 0);

    on_platform = 1;
    repeat (115) next_frame();
    chk("carry_up", 156, 5, 0, 115, 115, 0);
    next_frame();
    chk("fail_top", 156, 4, 0, 115, 116, 1);

    @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    chk("async_reset", 156, 120, 0, 0, 0, 0);
    check("async_reset.frame_tick", int'(frame_tick), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
